// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the pipeline hazard controller.
//   sb_entry_t   : one in-flight scoreboard entry (EXE..WB).
//   SB_AW_MAX    : storage width of register fields inside an entry; narrower
//                  register addresses are zero-extended into it.
//   SEL_REGFILE  : forwarding select value meaning "read the register file".
//   sel_width()  : width of a forwarding select for a given pipeline depth.
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int SB_AW_MAX   = 8;
   localparam int SEL_REGFILE = 0;

   // A select must encode 0..nstage-1; never narrower than one bit.
   function automatic int sel_width(input int nstage);
      return (nstage > 2) ? $clog2(nstage) : 1;
   endfunction

   typedef struct packed {
      logic                 valid;
      logic                 wb_en;
      logic                 mem_r_en;
      logic [SB_AW_MAX-1:0] dest;
      logic [SB_AW_MAX-1:0] src1;
      logic [SB_AW_MAX-1:0] src2;
      logic                 two_src;
   } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// -----------------------------------------------------------------------------
// sb_match
// Combinational comparator of one source register against every scoreboard
// entry.
//   live  : per entry, valid AND wb_en (the entry will write a register)
//   dests : per entry, destination register
//   src   : source register under test
//   match : bit k set when entry k writes src
// -----------------------------------------------------------------------------
module sb_match
   import pipe_pkg::*;
#(
   parameter int NSTAGE = 3
) (
   input  logic [NSTAGE-1:0]                live,
   input  logic [NSTAGE-1:0][SB_AW_MAX-1:0] dests,
   input  logic [SB_AW_MAX-1:0]             src,
   output logic [NSTAGE-1:0]                match
);

   always_comb begin
      for (int k = 0; k < NSTAGE; k++) begin
         match[k] = live[k] && (dests[k] == src);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Tracks the instructions in EXE..WB and produces the IF/ID freeze, the branch
// flush, per-operand forwarding selects and stall/flush statistics.
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   fwd_en          : 1 = forwarding mode, 0 = stall-only mode
//   id_*            : the instruction currently in ID (issue side)
//   br_taken        : branch resolved taken in EXE this cycle
//   mem_wait        : data memory busy, whole pipe holds
//   freeze, flush   : IF/ID hold and IF/ID + ID/EXE clear
//   sel_src1/2      : forwarding selects for the EXE operands (0 = regfile,
//                     k = forward from scoreboard entry k)
//   stall_cnt       : hazard-caused freeze cycles (saturating)
//   flush_cnt       : flush cycles (saturating)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW = 4,
   parameter int NSTAGE = 3,
   parameter int SEL_W  = sel_width(NSTAGE),
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fwd_en,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_src1,
   input  logic [REG_AW-1:0] id_src2,
   input  logic              id_two_src,
   input  logic              id_wb_en,
   input  logic              id_mem_r_en,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              br_taken,
   input  logic              mem_wait,
   output logic              freeze,
   output logic              flush,
   output logic [SEL_W-1:0]  sel_src1,
   output logic [SEL_W-1:0]  sel_src2,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   // Entries 0..NSTAGE-2 have not yet written the register file; WB has
   // (write-before-read), so stall-only mode ignores the last entry.
   localparam logic [NSTAGE-1:0] NO_WB_MASK = {1'b0, {(NSTAGE-1){1'b1}}};

   sb_entry_t [NSTAGE-1:0] sb_q, sb_d;
   logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;

   logic [NSTAGE-1:0]                live;
   logic [NSTAGE-1:0][SB_AW_MAX-1:0] dests;
   logic [NSTAGE-1:0]                m_id1, m_id2, m_ex1, m_ex2;
   logic [NSTAGE-1:0]                id_hit;
   logic                             hazard;
   logic [SEL_W-1:0]                 sel1, sel2;

   always_comb begin
      for (int k = 0; k < NSTAGE; k++) begin
         live[k]  = sb_q[k].valid & sb_q[k].wb_en;
         dests[k] = sb_q[k].dest;
      end
   end

   // Issue-side comparisons (ID sources) and EXE-side comparisons (operands
   // of the instruction sitting in entry 0).
   sb_match #(.NSTAGE(NSTAGE)) u_match_id1 (
      .live(live), .dests(dests), .src(SB_AW_MAX'(id_src1)), .match(m_id1));
   sb_match #(.NSTAGE(NSTAGE)) u_match_id2 (
      .live(live), .dests(dests), .src(SB_AW_MAX'(id_src2)), .match(m_id2));
   sb_match #(.NSTAGE(NSTAGE)) u_match_ex1 (
      .live(live), .dests(dests), .src(sb_q[0].src1), .match(m_ex1));
   sb_match #(.NSTAGE(NSTAGE)) u_match_ex2 (
      .live(live), .dests(dests), .src(sb_q[0].src2), .match(m_ex2));

   always_comb begin
      id_hit = m_id1 | (id_two_src ? m_id2 : '0);
      if (fwd_en) begin
         // Only a load still in EXE cannot forward in time (load-use).
         hazard = id_valid & id_hit[0] & sb_q[0].mem_r_en;
      end else begin
         hazard = id_valid & (|(id_hit & NO_WB_MASK));
      end
   end

   // Forward from the youngest producer: scanning from the oldest entry down
   // lets the smallest matching index overwrite the choice.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      sel1 = SEL_W'(SEL_REGFILE);
      sel2 = SEL_W'(SEL_REGFILE);
      for (int k = NSTAGE-1; k >= 1; k--) begin
         if (m_ex1[k]) sel1 = SEL_W'(k);
         if (m_ex2[k]) sel2 = SEL_W'(k);
      end
      if (!fwd_en || !sb_q[0].valid) begin
         sel1 = SEL_W'(SEL_REGFILE);
         sel2 = SEL_W'(SEL_REGFILE);
      end
      if (!sb_q[0].two_src) sel2 = SEL_W'(SEL_REGFILE);
   end

   always_comb begin
      sb_d        = sb_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!mem_wait) begin
         for (int k = NSTAGE-1; k >= 1; k--) begin
            sb_d[k] = sb_q[k-1];
         end
         sb_d[0] = '0;
         // A taken branch squashes the ID instruction even without a hazard.
         if (id_valid && !hazard && !br_taken) begin
            sb_d[0].valid    = 1'b1;
            sb_d[0].wb_en    = id_wb_en;
            sb_d[0].mem_r_en = id_mem_r_en;
            sb_d[0].dest     = SB_AW_MAX'(id_dest);
            sb_d[0].src1     = SB_AW_MAX'(id_src1);
            sb_d[0].src2     = SB_AW_MAX'(id_src2);
            sb_d[0].two_src  = id_two_src;
         end
         if (hazard && !br_taken && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
         if (br_taken && (flush_cnt_q != '1))            flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   // NOTE: the scoreboard is a handful of flops whose valid bits must be
   // cleared for the first cycle, so the whole array is reset, not just data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         sb_q        <= sb_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Outputs are held low while reset is asserted, even if mem_wait is high.
   assign freeze    = ~rst & (hazard | mem_wait);
   assign flush     = ~rst & br_taken & ~mem_wait;
   assign sel_src1  = sel1;
   assign sel_src2  = sel2;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

   // The retiring entry's operand fields and self-matches of entry 0 have no
   // consumer.
   logic unused_bits;
   assign unused_bits = ^{sb_q[NSTAGE-1].mem_r_en, sb_q[NSTAGE-1].src1,
                          sb_q[NSTAGE-1].src2, sb_q[NSTAGE-1].two_src,
                          m_ex1[0], m_ex2[0]};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl. A behavioural model keeps the
// in-flight instructions as records and derives freeze/flush/selects/counters
// from the pipeline rules; directed scenarios and a randomized run compare the
// DUT against it and against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam int NS      = 3;
   localparam int AW      = 4;
   localparam int SW      = 2;
   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic          fwd_en, id_valid, id_two_src, id_wb_en, id_mem_r_en;
   logic [AW-1:0] id_src1, id_src2, id_dest;
   logic          br_taken, mem_wait;
   logic          freeze, flush;
   logic [SW-1:0] sel_src1, sel_src2;
   logic [CW-1:0] stall_cnt, flush_cnt;

   pipe_hazard_ctrl #(.REG_AW(AW), .NSTAGE(NS), .SEL_W(SW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_valid(id_valid),
      .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
      .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
      .br_taken(br_taken), .mem_wait(mem_wait), .freeze(freeze), .flush(flush),
      .sel_src1(sel_src1), .sel_src2(sel_src2), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct {
      bit v; bit wb; bit ld; int dest; int s1; int s2; bit two;
   } ins_t;

   ins_t pipe [NS];       // pipe[0] = EXE ... pipe[NS-1] = WB
   ins_t cur;
   bit   cur_mw;
   int   m_stall, m_flush;
   bit   e_hazard, e_freeze, e_flush;
   int   e_sel1, e_sel2;
   int   tests_run    = 0;
   int   tests_failed = 0;

   function automatic ins_t mk(bit v, int s1, int s2, bit two, bit wb, bit ld, int d);
      ins_t i;
      i.v = v; i.s1 = s1; i.s2 = s2; i.two = two; i.wb = wb; i.ld = ld; i.dest = d;
      return i;
   endfunction

   function automatic ins_t bubble();
      return mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
   endfunction

   function automatic bit writes(ins_t p, int r);
      return p.v && p.wb && (p.dest == r);
   endfunction

   // Nearest producer of r older than the EXE instruction, 0 when none.
   function automatic int fwd_from(int r);
      for (int k = 1; k < NS; k++) if (writes(pipe[k], r)) return k;
      return 0;
   endfunction

   function automatic logic [2+2*SW-1:0] obs_out();
      return {freeze, flush, sel_src1, sel_src2};
   endfunction
   function automatic logic [2+2*SW-1:0] exp_out();
      return {e_freeze, e_flush, SW'(e_sel1), SW'(e_sel2)};
   endfunction
   function automatic logic [2*CW-1:0] obs_cnt();
      return {stall_cnt, flush_cnt};
   endfunction
   function automatic logic [2*CW-1:0] exp_cnt();
      return {CW'(m_stall), CW'(m_flush)};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NS; k++) pipe[k] = bubble();
      m_stall = 0;
      m_flush = 0;
   endtask

   // Apply one cycle's inputs (called at the falling edge) and derive the
   // expected combinational outputs from the current model contents.
   task automatic drive(input ins_t i, input bit br, input bit mw, input bit fe);
      bit uses;
      cur = i; cur_mw = mw;
      id_valid = i.v; id_src1 = AW'(i.s1); id_src2 = AW'(i.s2);
      id_two_src = i.two; id_wb_en = i.wb; id_mem_r_en = i.ld; id_dest = AW'(i.dest);
      br_taken = br; mem_wait = mw; fwd_en = fe;
      e_hazard = 1'b0;
      if (i.v) begin
         for (int k = 0; k < NS; k++) begin
            uses = writes(pipe[k], i.s1) || (i.two && writes(pipe[k], i.s2));
            // Without forwarding a value is only usable once it reached WB.
            if (uses && !fe && (k < NS-1)) e_hazard = 1'b1;
            // With forwarding only a load's data in EXE is too late.
            if (uses && fe && (k == 0) && pipe[k].ld) e_hazard = 1'b1;
         end
      end
      e_freeze = e_hazard || mw;
      e_flush  = br && !mw;
      e_sel1 = 0;
      e_sel2 = 0;
      if (fe && pipe[0].v) begin
         e_sel1 = fwd_from(pipe[0].s1);
         if (pipe[0].two) e_sel2 = fwd_from(pipe[0].s2);
      end
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!cur_mw) begin
         if (e_hazard && !e_flush && (m_stall < CNT_MAX)) m_stall++;
         if (e_flush && (m_flush < CNT_MAX)) m_flush++;
         for (int k = NS-1; k > 0; k--) pipe[k] = pipe[k-1];
         pipe[0] = (cur.v && !e_hazard && !e_flush) ? cur : bubble();
      end
      @(negedge clk);
   endtask

   task automatic drain(input bit fe);
      repeat (NS) begin
         drive(bubble(), 1'b0, 1'b0, fe);
         tick();
      end
   endtask

   function automatic int rnd_reg();
      int r;
      r = $urandom_range(0, 4);
      return (r == 4) ? 15 : r;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      drive(bubble(), 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (obs_out() !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h want 0", obs_out());
      end
      tests_run++;
      if (obs_cnt() !== '0) begin
         tests_failed++;
         $display("FAIL reset_counters: got %h want 0", obs_cnt());
      end
      @(negedge clk);
      rst = 1'b0;
      drive(bubble(), 1'b0, 1'b0, 1'b1);
      tests_run++;
      if ((obs_out() !== '0) || (obs_out() !== exp_out())) begin
         tests_failed++;
         $display("FAIL idle_outputs: got %h want 0", obs_out());
      end
      tick();
      tests_run++;
      if (obs_cnt() !== '0) begin
         tests_failed++;
         $display("FAIL idle_counters: got %h want 0", obs_cnt());
      end
   endtask

   task automatic test_stall_only();
      int base;
      base = m_stall;
      drive(mk(1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 3), 1'b0, 1'b0, 1'b0);
      tests_run++;
      if ((freeze !== 1'b0) || (obs_out() !== exp_out())) begin
         tests_failed++;
         $display("FAIL stall_add_issue: got %h want %h", obs_out(), exp_out());
      end
      tick();
      for (int c = 0; c < 3; c++) begin
         drive(mk(1'b1, 3, 0, 1'b0, 1'b1, 1'b0, 5), 1'b0, 1'b0, 1'b0);
         tests_run++;
         if ((freeze !== (c < 2)) || (obs_out() !== exp_out())) begin
            tests_failed++;
            $display("FAIL stall_sub_cycle%0d: freeze got %b want %b", c, freeze, (c < 2));
         end
         tick();
      end
      tests_run++;
      if ((stall_cnt !== CW'(base + 2)) || (obs_cnt() !== exp_cnt())) begin
         tests_failed++;
         $display("FAIL stall_count: got %0d want %0d", stall_cnt, base + 2);
      end
      drain(1'b0);
   endtask

   task automatic test_forwarding();
      drive(mk(1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 3), 1'b0, 1'b0, 1'b1);
      tick();
      drive(mk(1'b1, 3, 0, 1'b0, 1'b1, 1'b0, 5), 1'b0, 1'b0, 1'b1);
      tests_run++;
      if ((freeze !== 1'b0) || (obs_out() !== exp_out())) begin
         tests_failed++;
         $display("FAIL fwd_no_freeze: got %h want %h", obs_out(), exp_out());
      end
      tick();
      drive(mk(1'b1, 3, 0, 1'b0, 1'b1, 1'b0, 6), 1'b0, 1'b0, 1'b1);
      tests_run++;
      if ((sel_src1 !== 2'd1) || (obs_out() !== exp_out())) begin
         tests_failed++;
         $display("FAIL fwd_sel_mem: got %0d want 1", sel_src1);
      end
      tick();
      drive(bubble(), 1'b0, 1'b0, 1'b1);
      tests_run++;
      if ((sel_src1 !== 2'd2) || (obs_out() !== exp_out())) begin
         tests_failed++;
         $display("FAIL fwd_sel_wb: got %0d want 2", sel_src1);
      end
      tick();
      drain(1'b1);
   endtask

   task automatic test_load_use();
      int base;
      ins_t add;
      base = m_stall;
      add  = mk(1'b1, 1, 2, 1'b1, 1'b1, 1'b0, 7);
      drive(mk(1'b1, 0, 0, 1'b0, 1'b1, 1'b1, 2), 1'b0, 1'b0, 1'b1);
      tick();
      drive(add, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if ((freeze !== 1'b1) || (obs_out() !== exp_out())) begin
         tests_failed++;
         $display("FAIL ld_use_freeze: got %h want %h", obs_out(), exp_out());
      end
      tick();
      drive(add, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if ((freeze !== 1'b0) || (obs_out() !== exp_out())) begin
         tests_failed++;
         $display("FAIL ld_use_release: got %h want %h", obs_out(), exp_out());
      end
      tick();
      // EXE = ADD, MEM = bubble, WB = LDR.
      drive(bubble(), 1'b0, 1'b0, 1'b1);
      tests_run++;
      if ((sel_src2 !== 2'd2) || (sel_src1 !== 2'd0) || (obs_out() !== exp_out())) begin
         tests_failed++;
         $display("FAIL ld_use_sel: got src1=%0d src2=%0d want 0 2", sel_src1, sel_src2);
      end
      tick();
      tests_run++;
      if ((stall_cnt !== CW'(base + 1)) || (obs_cnt() !== exp_cnt())) begin
         tests_failed++;
         $display("FAIL ld_use_count: got %0d want %0d", stall_cnt, base + 1);
      end
      drain(1'b1);
   endtask

   task automatic test_flush();
      int sb, fb;
      sb = m_stall;
      fb = m_flush;
      drive(mk(1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 3), 1'b0, 1'b0, 1'b0);
      tick();
      drive(mk(1'b1, 3, 0, 1'b0, 1'b1, 1'b0, 8), 1'b1, 1'b0, 1'b0);
      tests_run++;
      if ((freeze !== 1'b1) || (flush !== 1'b1) || (obs_out() !== exp_out())) begin
         tests_failed++;
         $display("FAIL flush_pulse: got freeze=%b flush=%b want 1 1", freeze, flush);
      end
      tick();
      tests_run++;
      if ((stall_cnt !== CW'(sb)) || (flush_cnt !== CW'(fb + 1))) begin
         tests_failed++;
         $display("FAIL flush_counts: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, sb, fb + 1);
      end
      // A reader of R8 stalls only if the flushed instruction had been issued.
      drive(mk(1'b1, 8, 0, 1'b0, 1'b1, 1'b0, 9), 1'b0, 1'b0, 1'b0);
      tests_run++;
      if ((freeze !== 1'b0) || (obs_out() !== exp_out())) begin
         tests_failed++;
         $display("FAIL flush_bubbled: got freeze=%b want 0", freeze);
      end
      tick();
      drain(1'b0);
   endtask

   task automatic test_mem_wait();
      logic [2*CW-1:0] held_cnt;
      drive(mk(1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 4), 1'b0, 1'b0, 1'b1);
      tick();
      drive(mk(1'b1, 4, 0, 1'b0, 1'b1, 1'b0, 9), 1'b0, 1'b0, 1'b1);
      tick();
      held_cnt = exp_cnt();
      for (int c = 0; c < 4; c++) begin
         drive(mk(1'b1, 4, 0, 1'b0, 1'b1, 1'b1, 10), 1'b0, 1'b1, 1'b1);
         tests_run++;
         if ((freeze !== 1'b1) || (sel_src1 !== 2'd1) || (obs_out() !== exp_out())
             || (obs_cnt() !== held_cnt)) begin
            tests_failed++;
            $display("FAIL mem_wait_hold%0d: got %h/%h want %h/%h", c, obs_out(), obs_cnt(),
                     exp_out(), held_cnt);
         end
         if (c < 3) tick();
      end
      #1 rst = 1'b1;
      #1;
      model_reset();
      tests_run++;
      if ((obs_out() !== '0) || (obs_cnt() !== '0)) begin
         tests_failed++;
         $display("FAIL reset_mid_hold: got %h/%h want 0/0", obs_out(), obs_cnt());
      end
      @(negedge clk);
      rst = 1'b0;
      drive(mk(1'b1, 4, 0, 1'b0, 1'b1, 1'b0, 10), 1'b0, 1'b0, 1'b0);
      tests_run++;
      if ((freeze !== 1'b0) || (obs_out() !== exp_out())) begin
         tests_failed++;
         $display("FAIL post_reset_freeze: got %b want 0", freeze);
      end
      tick();
      drain(1'b0);
   endtask

   task automatic test_random();
      ins_t i;
      bit   fe, br, mw;
      for (int n = 0; n < 400; n++) begin
         fe = ((n / 50) % 2) == 1;
         i  = mk($urandom_range(0, 3) != 0, rnd_reg(), rnd_reg(), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rnd_reg());
         br = $urandom_range(0, 7) == 0;
         mw = $urandom_range(0, 5) == 0;
         drive(i, br, mw, fe);
         tests_run++;
         if (obs_out() !== exp_out()) begin
            tests_failed++;
            $display("FAIL random_out cycle %0d: got %h want %h", n, obs_out(), exp_out());
         end
         tick();
         tests_run++;
         if (obs_cnt() !== exp_cnt()) begin
            tests_failed++;
            $display("FAIL random_cnt cycle %0d: got %h want %h", n, obs_cnt(), exp_cnt());
         end
      end
      drain(1'b0);
   endtask

   task automatic test_saturation();
      for (int c = 0; c < 10; c++) begin
         drive(mk(1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 3), 1'b0, 1'b0, 1'b0);
         tick();
         repeat (3) begin
            drive(mk(1'b1, 3, 0, 1'b0, 1'b1, 1'b0, 5), 1'b0, 1'b0, 1'b0);
            tick();
         end
      end
      repeat (CNT_MAX + 3) begin
         drive(bubble(), 1'b1, 1'b0, 1'b0);
         tick();
      end
      tests_run++;
      if ((stall_cnt !== CW'(CNT_MAX)) || (flush_cnt !== CW'(CNT_MAX))) begin
         tests_failed++;
         $display("FAIL saturation: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt,
                  CNT_MAX, CNT_MAX);
      end
   endtask

   initial begin
      test_reset();
      test_stall_only();
      test_forwarding();
      test_load_use();
      test_flush();
      test_mem_wait();
      test_random();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
